// File: rtl/zero_count_serial_pkg.sv
// Shared types and width helpers for the serial zero counter.
package zc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } zc_state_t;

  // The count register must hold the value WIDTH itself (all-zero sample).
  function automatic int zc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int ZC_WIDTH = 8;
  localparam int ZC_LED_W = 8;

endpackage

// File: rtl/zero_count_serial_thermo.sv
// Count-to-thermometer decoder: bit k lights when k is below the count.
// A count of 8 or more lights every LED.
module zc_thermo_decode
  import zc_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0]    count,
  output logic [ZC_LED_W-1:0] therm
);

  // Each LED compares its own position against the count.
  always_comb begin
    therm = '0;
    for (int k = 0; k < ZC_LED_W; k++) begin
      therm[k] = (int'(count) > k);
    end
  end

endmodule

// File: rtl/zero_count_serial.sv
// Serial zero counter: accepts a sample over valid/ready, examines one bit
// per enabled clock, then offers the count to the consumer and latches an
// LED thermometer of that result.
module zero_count_serial
  import zc_pkg::*;
#(
  parameter  int WIDTH = ZC_WIDTH,
  localparam int CNT_W = zc_cnt_w(WIDTH)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    number,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    zero_count,
  output logic [ZC_LED_W-1:0] led
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  zc_state_t              state;
  logic [WIDTH-1:0]       shreg;
  logic [CNT_W-1:0]       idx;
  logic [CNT_W-1:0]       acc;
  logic [CNT_W-1:0]       acc_next;
  logic [ZC_LED_W-1:0]    led_next;

  // Accumulator value including the bit currently at the bottom of the shifter.
  always_comb begin
    acc_next = acc + {{(CNT_W-1){1'b0}}, ~shreg[0]};
  end

  zc_thermo_decode #(
    .CNT_W (CNT_W)
  ) u_thermo (
    .count (acc_next),
    .therm (led_next)
  );

  // Ready follows enable only while idle and held low while in reset.
  always_comb begin
    in_ready = (state == IDLE) && enable && RST;
  end

  // Control FSM with shifter, counters and registered result outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      zero_count <= '0;
      led        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && in_valid) begin
            shreg <= number;
            acc   <= '0;
            idx   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (enable) begin
            acc   <= acc_next;
            shreg <= shreg >> 1;
            idx   <= idx + CNT_W'(1);
            if (idx == LAST_IDX) begin
              zero_count <= acc_next;
              led        <= led_next;
              out_valid  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zero_count_serial.sv
// Bench for zero_count_serial: table vectors, randomized transactions,
// async reset abort and back-to-back throughput.
module tb_zero_count_serial;

  logic       CLK;
  logic       RST;
  logic       enable;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] number;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] zero_count;
  logic [7:0] led;

  int total = 0;
  int bad   = 0;

  zero_count_serial #(.WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .number     (number),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .zero_count (zero_count),
    .led        (led)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] number;
    int         stall_at;
    int         stall_len;
    int         hold;
    logic [3:0] exp_zc;
    logic [7:0] exp_led;
  } vec_t;

  // Reference: zeros are the bits not set; LEDs light one per zero, capped at 8.
  function automatic int model_zeros(input logic [7:0] n);
    return 8 - $countones(n);
  endfunction

  function automatic logic [7:0] model_led(input int z);
    logic [8:0] t;
    t = (9'd1 << (z > 8 ? 8 : z)) - 9'd1;
    return t[7:0];
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full transaction from IDLE: accept, shift with optional stall,
  // hold in DONE for a while, then hand off to the consumer.
  task automatic apply_stimulus(input string name, input logic [7:0] n,
                                input int stall_at, input int stall_len, input int hold,
                                input logic [3:0] exp_zc, input logic [7:0] exp_led);
    int cyc;
    int en_cnt;
    logic [3:0] held_zc;
    enable    = 1'b1;
    in_valid  = 1'b1;
    number    = n;
    out_ready = 1'b0;
    #1;
    check_output({name, "_in_ready_idle"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    number   = 8'($urandom);
    check_output({name, "_in_ready_shift"}, int'(in_ready), 0);
    cyc    = 0;
    en_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      enable    = !(c >= stall_at && c < stall_at + stall_len);
      out_ready = 1'($urandom);
      tick();
      cyc++;
      if (enable) en_cnt++;
      number = 8'($urandom);
      if (out_valid) break;
    end
    out_ready = 1'b0;
    enable    = 1'b1;
    check_output({name, "_out_valid"}, int'(out_valid), 1);
    check_output({name, "_latency_en"}, en_cnt, 8);
    check_output({name, "_latency_cyc"}, cyc, 8 + stall_len);
    check_output({name, "_zero_count"}, int'(zero_count), int'(exp_zc));
    check_output({name, "_led"}, int'(led), int'(exp_led));
    held_zc  = zero_count;
    in_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      enable = 1'($urandom);
      tick();
      check_output({name, "_hold_valid"}, int'(out_valid), 1);
      check_output({name, "_hold_zc"}, int'(zero_count), int'(held_zc));
      check_output({name, "_hold_in_ready"}, int'(in_ready), 0);
    end
    enable    = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_output({name, "_released"}, int'(out_valid), 0);
    check_output({name, "_led_kept"}, int'(led), int'(exp_led));
  endtask

  vec_t vecs[6];

  initial begin
    int accepts;
    int outputs;
    int last_acc;
    int acc_q[$];
    logic [7:0] rn;
    int z;

    vecs[0] = '{8'h00, 99, 0, 0, 4'd8, 8'hFF};
    vecs[1] = '{8'hFF, 99, 0, 0, 4'd0, 8'h00};
    vecs[2] = '{8'hA5, 99, 0, 0, 4'd4, 8'h0F};
    vecs[3] = '{8'h01, 2,  3, 0, 4'd7, 8'h7F};
    vecs[4] = '{8'h80, 99, 0, 5, 4'd7, 8'h7F};
    vecs[5] = '{8'h3C, 5,  2, 2, 4'd4, 8'h0F};

    RST       = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b1;
    number    = 8'h00;
    out_ready = 1'b0;
    #12;
    check_output("reset_in_ready", int'(in_ready), 0);
    check_output("reset_out_valid", int'(out_valid), 0);
    check_output("reset_zero_count", int'(zero_count), 0);
    check_output("reset_led", int'(led), 0);
    in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].number, vecs[i].stall_at,
                     vecs[i].stall_len, vecs[i].hold, vecs[i].exp_zc, vecs[i].exp_led);
    end

    // Async reset while shifting discards the partial result.
    enable   = 1'b1;
    in_valid = 1'b1;
    number   = 8'h00;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    RST = 1'b0;
    #2;
    check_output("abort_in_ready", int'(in_ready), 0);
    check_output("abort_out_valid", int'(out_valid), 0);
    check_output("abort_zero_count", int'(zero_count), 0);
    check_output("abort_led", int'(led), 0);
    @(negedge CLK);
    RST = 1'b1;
    tick();
    apply_stimulus("after_abort", 8'h0F, 99, 0, 0, 4'd4, 8'h0F);

    // Randomized transactions against the reference model.
    for (int r = 0; r < 20; r++) begin
      rn = 8'($urandom);
      z  = model_zeros(rn);
      apply_stimulus($sformatf("rand%0d", r), rn, int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                     4'(z), model_led(z));
    end

    // Back-to-back: always valid, always ready; one accept every 10 cycles.
    enable    = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    number    = 8'($urandom);
    accepts   = 0;
    outputs   = 0;
    last_acc  = -1;
    for (int c = 0; c < 70; c++) begin
      logic took;
      if (c == 52) in_valid = 1'b0;
      @(negedge CLK);
      took = in_valid && in_ready;
      if (took) begin
        acc_q.push_back(model_zeros(number));
        if (last_acc >= 0) check_output("b2b_interval", c - last_acc, 10);
        last_acc = c;
        accepts++;
      end
      if (out_valid && out_ready) begin
        outputs++;
        if (acc_q.size() == 0) begin
          check_output("b2b_unexpected_output", 1, 0);
        end else begin
          check_output("b2b_zero_count", int'(zero_count), acc_q.pop_front());
        end
      end
      @(posedge CLK);
      #1;
      if (took) number = 8'($urandom);
    end
    check_output("b2b_accepts", accepts, 6);
    check_output("b2b_outputs", outputs, accepts);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
